accel_shot_detector: RTL and testbench

//  Consumes 16-bit X-axis accelerometer samples from the ADXL362 SPI reader and

---
 rtl/accel_shot_detector.sv | 201 ++++++++++++++++++++
 tb/tb_accel_shot_detector.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_shot_detector.sv
`default_nettype none
// ============================================================================
//  Module   : accel_shot_detector
//  Purpose  : Smooths 16-bit X-axis accelerometer samples with a power-of-two
//             moving average and detects one basketball shot gesture per
//             swing (rest -> swing -> release). Each detected shot produces a
//             single-cycle pulse carrying the peak filtered value and the
//             swing duration in samples.
//  Ports    : CLK100MHZ  in   system clock
//             rst        in   synchronous reset, active-high
//             x_raw      in   16b two's-complement X sample
//             x_valid    in   one sample per high cycle
//             filt_x     out  16b signed moving average
//             filt_valid out  pulse, filt_x updated (1 cycle after x_valid)
//             shot_valid out  pulse, shot detected (1 cycle after filt_valid)
//             shot_peak  out  16b signed peak of the last shot (held)
//             shot_dur   out  8b swing length of the last shot (held)
//             state_dbg  out  0=FILL 1=WAIT_REST 2=SWING 3=COOLDOWN
//  Revision : 1.0  initial release
// ============================================================================
module accel_shot_detector #(
  parameter int AVG_LOG2         = 3,
  parameter int REST_BAND        = 64,
  parameter int REST_SAMPLES     = 8,
  parameter int TRIG_THRESH      = 600,
  parameter int DROP             = 200,
  parameter int MAX_SWING        = 200,
  parameter int COOLDOWN_SAMPLES = 64
) (
  input  logic               CLK100MHZ,
  input  logic               rst,
  input  logic signed [15:0] x_raw,
  input  logic               x_valid,
  output logic signed [15:0] filt_x,
  output logic               filt_valid,
  output logic               shot_valid,
  output logic signed [15:0] shot_peak,
  output logic        [7:0]  shot_dur,
  output logic        [1:0]  state_dbg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = 16 + AVG_LOG2;

  localparam logic signed [15:0] REST_HI   = 16'(REST_BAND);
  localparam logic signed [15:0] REST_LO   = 16'(-REST_BAND);
  localparam logic signed [15:0] TRIG      = 16'(TRIG_THRESH);
  localparam logic signed [16:0] DROP_V    = 17'(DROP);
  localparam logic        [7:0]  REST_N    = 8'(REST_SAMPLES);
  localparam logic        [7:0]  MAX_N     = 8'(MAX_SWING);
  localparam logic        [7:0]  FILL_LAST = 8'(DEPTH - 1);
  localparam logic        [7:0]  COOL_LAST = 8'(COOLDOWN_SAMPLES - 1);
  localparam logic [AVG_LOG2-1:0] WP_INC   = AVG_LOG2'(1);

  // --------------------------------------------------------------------------
  // Moving-average filter
  // --------------------------------------------------------------------------
  logic signed [15:0]   ring [DEPTH];
  logic [AVG_LOG2-1:0]  wp;
  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] x_ext;
  logic signed [SW-1:0] old_ext;
  logic signed [SW-1:0] sum_next;

  always_comb begin
    x_ext    = {{AVG_LOG2{x_raw[15]}}, x_raw};
    old_ext  = {{AVG_LOG2{ring[wp][15]}}, ring[wp]};
    sum_next = sum + x_ext - old_ext;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
      wp         <= '0;
      sum        <= '0;
      filt_x     <= '0;
      filt_valid <= 1'b0;
    end else begin
      filt_valid <= x_valid;
      if (x_valid) begin
        sum      <= sum_next;
        ring[wp] <= x_raw;
        wp       <= wp + WP_INC;
        // The sum of DEPTH 16-bit samples never exceeds SW bits, so the low
        // 16 bits above the fraction are exactly sum >>> AVG_LOG2.
        filt_x   <= sum_next[AVG_LOG2 +: 16];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Gesture state machine (advances on filt_valid only)
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    WAIT_REST = 2'd1,
    SWING     = 2'd2,
    COOLDOWN  = 2'd3
  } state_t;

  state_t             state;
  logic [7:0]         cnt;
  logic [7:0]         rest_cnt;
  logic [7:0]         dur;
  logic signed [15:0] peak;

  logic               at_rest;
  logic               armed;
  logic               trig;
  logic               release_hit;
  logic [7:0]         dur_inc;
  logic signed [16:0] filt17;
  logic signed [16:0] drop_lvl;

  always_comb begin
    at_rest     = (filt_x >= REST_LO) && (filt_x <= REST_HI);
    armed       = (rest_cnt >= REST_N);
    trig        = (filt_x >= TRIG);
    filt17      = {filt_x[15], filt_x};
    // 17-bit threshold so a very negative peak cannot wrap positive.
    drop_lvl    = {peak[15], peak} - DROP_V;
    release_hit = (filt17 <= drop_lvl);
    dur_inc     = dur + 8'd1;
  end

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      state      <= FILL;
      cnt        <= '0;
      rest_cnt   <= '0;
      dur        <= '0;
      peak       <= '0;
      shot_valid <= 1'b0;
      shot_peak  <= '0;
      shot_dur   <= '0;
    end else begin
      shot_valid <= 1'b0;
      if (filt_valid) begin
        case (state)
          FILL: begin
            if (cnt == FILL_LAST) begin
              state    <= WAIT_REST;
              cnt      <= '0;
              rest_cnt <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end

          WAIT_REST: begin
            // Arming uses the rest count accumulated before this sample.
            if (armed && trig) begin
              state    <= SWING;
              peak     <= filt_x;
              dur      <= 8'd1;
              rest_cnt <= '0;
            end else if (at_rest) begin
              if (rest_cnt != 8'hFF) rest_cnt <= rest_cnt + 8'd1;
            end else if (!armed) begin
              rest_cnt <= '0;
            end
            // Once armed, the averaged ramp between the rest band and the
            // trigger level must not disarm, so the count is held there.
          end

          SWING: begin
            if (release_hit) begin
              shot_valid <= 1'b1;
              shot_peak  <= peak;
              shot_dur   <= dur_inc;
              state      <= COOLDOWN;
              cnt        <= '0;
            end else if (dur_inc >= MAX_N) begin
              state <= COOLDOWN;
              cnt   <= '0;
            end else begin
              dur <= dur_inc;
              if (filt_x > peak) peak <= filt_x;
            end
          end

          COOLDOWN: begin
            if (cnt == COOL_LAST) begin
              state    <= WAIT_REST;
              cnt      <= '0;
              rest_cnt <= '0;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end

          default: state <= FILL;
        endcase
      end
    end
  end

  assign state_dbg = state;

endmodule
`default_nettype wire

// File: tb/tb_accel_shot_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_accel_shot_detector
//  Purpose  : Directed self-checking bench for accel_shot_detector. A default
//             instance and a MAX_SWING=10 instance share the same stimulus.
//  Revision : 1.0  initial release
// ============================================================================
module tb_accel_shot_detector;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] x_raw = '0;
  logic               x_valid = 1'b0;

  logic signed [15:0] filt_x, shot_peak;
  logic               filt_valid, shot_valid;
  logic        [7:0]  shot_dur;
  logic        [1:0]  state_dbg;

  logic signed [15:0] filt_x_t, shot_peak_t;
  logic               filt_valid_t, shot_valid_t;
  logic        [7:0]  shot_dur_t;
  logic        [1:0]  state_dbg_t;

  int n_checks = 0;
  int n_fail   = 0;
  int shot_cnt = 0;
  int shot_cnt_t = 0;
  int shot_dbl = 0;
  logic shot_prev = 1'b0;

  always #5 clk = ~clk;

  accel_shot_detector dut (
    .CLK100MHZ (clk),        .rst        (rst),
    .x_raw     (x_raw),      .x_valid    (x_valid),
    .filt_x    (filt_x),     .filt_valid (filt_valid),
    .shot_valid(shot_valid), .shot_peak  (shot_peak),
    .shot_dur  (shot_dur),   .state_dbg  (state_dbg)
  );

  accel_shot_detector #(.MAX_SWING(10)) dut_t (
    .CLK100MHZ (clk),          .rst        (rst),
    .x_raw     (x_raw),        .x_valid    (x_valid),
    .filt_x    (filt_x_t),     .filt_valid (filt_valid_t),
    .shot_valid(shot_valid_t), .shot_peak  (shot_peak_t),
    .shot_dur  (shot_dur_t),   .state_dbg  (state_dbg_t)
  );

  // Shot pulse observers (read-only from the test tasks).
  always @(negedge clk) begin
    if (shot_valid) shot_cnt++;
    if (shot_valid_t) shot_cnt_t++;
    if (shot_valid && shot_prev) shot_dbl++;
    shot_prev = shot_valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "watchdog");
  end

  // One sample: strobe for one cycle, then one idle cycle so the FSM decision
  // for that sample is visible when the task returns.
  task automatic send(input logic signed [15:0] v);
    x_raw = v; x_valid = 1'b1;
    @(posedge clk); #1;
    x_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_n(input logic signed [15:0] v, input int n);
    for (int i = 0; i < n; i++) send(v);
  endtask

  task automatic do_reset();
    rst = 1'b1; x_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x_raw = 16'sh1234;
    for (int i = 0; i < 3; i++) begin
      x_valid = i[0] ? 1'b0 : 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if ({filt_x, filt_valid, shot_valid, shot_peak, shot_dur} !== 42'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got filt=%0d fv=%b sv=%b peak=%0d dur=%0d, expected all 0",
               filt_x, filt_valid, shot_valid, shot_peak, shot_dur);
    end
    n_checks++;
    if (state_dbg !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_state: got %0d expected 0", state_dbg);
    end
    rst = 1'b0; x_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_filter();
    logic signed [15:0] exp_f;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      exp_f = (i <= 8) ? 16'(100 * i) : 16'sd700;
      x_raw = (i <= 8) ? 16'sd800 : 16'sd0;
      x_valid = 1'b1;
      @(posedge clk); #1;
      x_valid = 1'b0;
      n_checks++;
      if (filt_valid !== 1'b1 || filt_x !== exp_f) begin
        n_fail++;
        $display("FAIL filter_value[%0d]: got fv=%b filt=%0d expected fv=1 filt=%0d",
                 i, filt_valid, filt_x, exp_f);
      end
      @(posedge clk); #1;
      n_checks++;
      if (filt_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL filter_pulse_width[%0d]: got fv=%b expected 0", i, filt_valid);
      end
      if (i == 7) begin
        n_checks++;
        if (state_dbg !== 2'd0) begin
          n_fail++;
          $display("FAIL fill_state_7: got %0d expected 0", state_dbg);
        end
      end
      if (i >= 8) begin
        n_checks++;
        if (state_dbg !== 2'd1) begin
          n_fail++;
          $display("FAIL fill_done_state[%0d]: got %0d expected 1", i, state_dbg);
        end
      end
    end
  endtask

  task automatic test_shot();
    int base;
    do_reset();
    base = shot_cnt;
    send_n(16'sd0, 16);
    send_n(16'sd1000, 4);
    n_checks++;
    if (state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL shot_pre_trigger_state: got %0d expected 1", state_dbg);
    end
    send(16'sd1000);
    n_checks++;
    if (state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL shot_trigger_state: got %0d expected 2", state_dbg);
    end
    send_n(16'sd1000, 11);
    send(16'sd0);
    n_checks++;
    if (shot_cnt - base !== 0 || state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL shot_no_early_release: got shots=%0d state=%0d expected 0 and 2",
               shot_cnt - base, state_dbg);
    end
    send(16'sd0);
    n_checks++;
    if (shot_valid !== 1'b1 || shot_peak !== 16'sd1000 || shot_dur !== 8'd14 || state_dbg !== 2'd3) begin
      n_fail++;
      $display("FAIL shot_release: got sv=%b peak=%0d dur=%0d state=%0d expected 1 1000 14 3",
               shot_valid, shot_peak, shot_dur, state_dbg);
    end
    send_n(16'sd0, 63);
    n_checks++;
    if (state_dbg !== 2'd3 || shot_peak !== 16'sd1000 || shot_dur !== 8'd14) begin
      n_fail++;
      $display("FAIL cooldown_hold: got state=%0d peak=%0d dur=%0d expected 3 1000 14",
               state_dbg, shot_peak, shot_dur);
    end
    send(16'sd0);
    n_checks++;
    if (state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL cooldown_exit: got %0d expected 1", state_dbg);
    end
    n_checks++;
    if (shot_cnt - base !== 1 || shot_dbl !== 0) begin
      n_fail++;
      $display("FAIL shot_count: got shots=%0d double=%0d expected 1 0", shot_cnt - base, shot_dbl);
    end
  endtask

  task automatic test_no_rest();
    int base;
    do_reset();
    base = shot_cnt;
    send_n(16'sd0, 11);
    send_n(16'sd1000, 32);
    n_checks++;
    if (shot_cnt - base !== 0 || state_dbg !== 2'd1 || filt_x !== 16'sd1000) begin
      n_fail++;
      $display("FAIL no_rest: got shots=%0d state=%0d filt=%0d expected 0 1 1000",
               shot_cnt - base, state_dbg, filt_x);
    end
  endtask

  task automatic test_timeout();
    int base_t;
    do_reset();
    base_t = shot_cnt_t;
    send_n(16'sd0, 16);
    send_n(16'sd1000, 13);
    n_checks++;
    if (state_dbg_t !== 2'd2) begin
      n_fail++;
      $display("FAIL timeout_before: got %0d expected 2", state_dbg_t);
    end
    send(16'sd1000);
    n_checks++;
    if (state_dbg_t !== 2'd3) begin
      n_fail++;
      $display("FAIL timeout_abort: got %0d expected 3", state_dbg_t);
    end
    send_n(16'sd1000, 26);
    n_checks++;
    if (shot_cnt_t - base_t !== 0 || state_dbg_t !== 2'd3 || state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL timeout_after: got shots=%0d state_t=%0d state=%0d expected 0 3 2",
               shot_cnt_t - base_t, state_dbg_t, state_dbg);
    end
  endtask

  task automatic test_cooldown_neg();
    int base;
    do_reset();
    base = shot_cnt;
    send_n(16'sd0, 16);
    send_n(16'sd1000, 16);
    send_n(16'sd0, 2);
    send_n(16'sd1000, 16);
    send_n(16'sd0, 16);
    n_checks++;
    if (shot_cnt - base !== 1 || state_dbg !== 2'd3) begin
      n_fail++;
      $display("FAIL cooldown_ignore: got shots=%0d state=%0d expected 1 3",
               shot_cnt - base, state_dbg);
    end

    do_reset();
    base = shot_cnt;
    send_n(-16'sd1000, 8);
    n_checks++;
    if (filt_x !== 16'hFC18) begin
      n_fail++;
      $display("FAIL negative_filter: got %h expected fc18", filt_x);
    end
    send_n(-16'sd1000, 24);
    n_checks++;
    if (shot_cnt - base !== 0 || state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL negative_no_trigger: got shots=%0d state=%0d expected 0 1",
               shot_cnt - base, state_dbg);
    end

    do_reset();
    base = shot_cnt;
    send_n(16'sd0, 16);
    send_n(16'sd1000, 8);
    n_checks++;
    if (state_dbg !== 2'd2) begin
      n_fail++;
      $display("FAIL midswing_pre: got %0d expected 2", state_dbg);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (state_dbg !== 2'd0 || shot_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midswing_reset: got state=%0d sv=%b expected 0 0", state_dbg, shot_valid);
    end
    rst = 1'b0;
    send_n(16'sd0, 16);
    n_checks++;
    if (shot_cnt - base !== 0 || state_dbg !== 2'd1) begin
      n_fail++;
      $display("FAIL midswing_after: got shots=%0d state=%0d expected 0 1",
               shot_cnt - base, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_filter();
    test_shot();
    test_no_rest();
    test_timeout();
    test_cooldown_neg();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
